brr_bank_ctrl: RTL and testbench

BRR_BANK_CTRL -- requirements
Module: brr_bank_ctrl

---
 rtl/brr_bank_ctrl.sv | 169 ++++++++++++++++
 tb/tb_brr_bank_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brr_bank_ctrl.sv
// brr_bank_ctrl: ping-pong bank controller that turns a bit-reversed FFT
// output stream into natural order. Samples are written into one of two RAM
// banks at bit-reversed addresses while the other bank is read out in natural
// order. Each bank carries a small state machine:
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   EMPTY    | no data, writer may start a frame here
//   FILLING  | writer has stored part of a frame
//   FULL     | complete frame stored, reader has not started on it
//   DRAINING | reader is walking through the frame
//
// N must be a power of two and BITS must equal log2(N).
module brr_bank_ctrl #(
  parameter int N    = 128,
  parameter int BITS = 7
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic            wr_en,
  output logic            wr_bank,
  output logic [BITS-1:0] wr_addr,
  output logic            rd_en,
  output logic            rd_bank,
  output logic [BITS-1:0] rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [3:0]      bank_state
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_t;

  localparam logic [BITS-1:0] LAST = BITS'(N - 1);

  bank_t           bank_q [2];
  bank_t           bank_d [2];
  logic            wb_q, wb_d;
  logic            rb_q, rb_d;
  logic [BITS-1:0] wcnt_q, wcnt_d;
  logic [BITS-1:0] rcnt_q, rcnt_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;

  logic            wr_open;
  logic            rd_avail;
  logic            wr_wrap;
  logic            rd_wrap;
  logic            out_stall;

  function automatic logic [BITS-1:0] bitrev(input logic [BITS-1:0] v);
    logic [BITS-1:0] r;
    r = '0;
    for (int i = 0; i < BITS; i++) begin
      r[BITS-1-i] = v[i];
    end
    return r;
  endfunction

  // Handshake decode: writer needs a writable bank, reader a loaded bank and
  // a free output slot. Flush and reset silence both strobes.
  always_comb begin
    wr_open   = (bank_q[wb_q] == EMPTY) || (bank_q[wb_q] == FILLING);
    rd_avail  = (bank_q[rb_q] == FULL) || (bank_q[rb_q] == DRAINING);
    out_stall = out_valid_q & ~out_ready;
    wr_wrap   = (wcnt_q == LAST);
    rd_wrap   = (rcnt_q == LAST);
    in_ready  = reset_n & ~flush & wr_open;
    wr_en     = in_valid & in_ready;
    rd_en     = reset_n & ~flush & rd_avail & (~out_valid_q | out_ready);
  end

  // Next-state logic for both bank FSMs, the pointers and the output slot.
  // A bank released by the reader only becomes writable after the edge, so
  // there is no same-cycle bypass from reader to writer.
  always_comb begin
    bank_d[0]   = bank_q[0];
    bank_d[1]   = bank_q[1];
    wb_d        = wb_q;
    rb_d        = rb_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    out_valid_d = rd_en | out_stall;
    out_last_d  = rd_en ? rd_wrap : (out_stall & out_last_q);

    if (flush) begin
      bank_d[0]   = EMPTY;
      bank_d[1]   = EMPTY;
      wb_d        = 1'b0;
      rb_d        = 1'b0;
      wcnt_d      = '0;
      rcnt_d      = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      // Writer and reader never own the same bank, so both updates can apply.
      for (int i = 0; i < 2; i++) begin
        if (wr_en && (wb_q == 1'(i))) begin
          bank_d[i] = wr_wrap ? FULL : FILLING;
        end
        if (rd_en && (rb_q == 1'(i))) begin
          bank_d[i] = rd_wrap ? EMPTY : DRAINING;
        end
      end

      if (wr_en) begin
        if (wr_wrap) begin
          wcnt_d = '0;
          wb_d   = ~wb_q;
        end else begin
          wcnt_d = wcnt_q + BITS'(1);
        end
      end

      if (rd_en) begin
        if (rd_wrap) begin
          rcnt_d = '0;
          rb_d   = ~rb_q;
        end else begin
          rcnt_d = rcnt_q + BITS'(1);
        end
      end
    end
  end

  // State register; reset clears everything immediately, even mid-frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bank_q[0]   <= EMPTY;
      bank_q[1]   <= EMPTY;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign wr_bank    = wb_q;
  assign rd_bank    = rb_q;
  assign wr_addr    = bitrev(wcnt_q);
  assign rd_addr    = rcnt_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign bank_state = {bank_q[1], bank_q[0]};

  // A simultaneous write and read must always target different banks.
  a_bank_split : assert property (@(posedge clock) disable iff (!reset_n)
    (wr_en && rd_en) |-> (wr_bank != rd_bank));

endmodule

// File: tb/tb_brr_bank_ctrl.sv
// Bench for brr_bank_ctrl at N=8: a directed vector table, hand sequences for
// stall/flush/async-reset corners, and a long random run against a
// frame-counting reference model with a behavioural two-bank RAM.
module tb_brr_bank_ctrl;

  localparam int N    = 8;
  localparam int BITS = 3;

  logic            clock;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic            wr_en;
  logic            wr_bank;
  logic [BITS-1:0] wr_addr;
  logic            rd_en;
  logic            rd_bank;
  logic [BITS-1:0] rd_addr;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic [3:0]      bank_state;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: W samples written, R samples read from RAM, outcnt
  // samples accepted downstream, all since the last reset/flush.
  int   w_cnt, r_cnt, outcnt;
  int   acc_seg, lasts_seg;
  logic e_ir, e_wr, e_rd, e_ov, e_acc;

  int din;
  int mem [2][N];
  int rdata;

  int   run, total;
  bit   ended;
  logic iv_r, or_r, fl_r;

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       ir;
    logic       we;
    logic [2:0] wa;
    logic       re;
    logic [2:0] ra;
    logic       ov;
    logic       ol;
    logic [3:0] bs;
  } vec_t;

  vec_t tbl [18];

  brr_bank_ctrl #(.N(N), .BITS(BITS)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_bank    (wr_bank),
    .wr_addr    (wr_addr),
    .rd_en      (rd_en),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .bank_state (bank_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Two-bank sample RAM driven by the DUT strobes; read data held when idle.
  always @(posedge clock) begin
    if (wr_en) mem[wr_bank][wr_addr] <= din;
    if (rd_en) rdata <= mem[rd_bank][rd_addr];
  end

  function automatic int brev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < BITS; i++) begin
      if (v[i]) r = r | (1 << (BITS - 1 - i));
    end
    return r;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_zero();
    w_cnt     = 0;
    r_cnt     = 0;
    outcnt    = 0;
    acc_seg   = 0;
    lasts_seg = 0;
  endfunction

  // Bank occupancy from frame counts: frames in [fr, fw) are complete and not
  // fully read; the oldest one is DRAINING once reading has started on it.
  function automatic logic [3:0] exp_banks();
    logic [1:0] st [2];
    int fw, fr;
    st[0] = 2'd0;
    st[1] = 2'd0;
    fw = w_cnt / N;
    fr = r_cnt / N;
    for (int f = fr; f < fw; f++) begin
      st[f % 2] = ((f == fr) && (r_cnt % N != 0)) ? 2'd3 : 2'd2;
    end
    if (w_cnt % N != 0) st[fw % 2] = 2'd1;
    return {st[1], st[0]};
  endfunction

  task automatic drive(input logic iv, input logic ordy, input logic fl);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    // Upstream tags each sample with its natural index within the stream.
    din       = (w_cnt / N) * N + brev(w_cnt % N);
  endtask

  task automatic check_model();
    @(negedge clock);
    e_ir  = reset_n && !flush && ((w_cnt / N - r_cnt / N) < 2);
    e_wr  = in_valid && e_ir;
    e_ov  = (r_cnt > outcnt);
    e_rd  = reset_n && !flush && (r_cnt < (w_cnt / N) * N) && (!e_ov || out_ready);
    e_acc = reset_n && !flush && e_ov && out_ready;
    chk("in_ready",   in_ready,   e_ir);
    chk("wr_en",      wr_en,      e_wr);
    chk("wr_bank",    wr_bank,    (w_cnt / N) % 2);
    chk("wr_addr",    wr_addr,    brev(w_cnt % N));
    chk("rd_en",      rd_en,      e_rd);
    chk("rd_bank",    rd_bank,    (r_cnt / N) % 2);
    chk("rd_addr",    rd_addr,    r_cnt % N);
    chk("out_valid",  out_valid,  e_ov);
    chk("out_last",   out_last,   e_ov && (outcnt % N == N - 1));
    chk("bank_state", bank_state, exp_banks());
    if (e_acc) chk("out_data", rdata, outcnt);
    if (out_valid && out_ready && reset_n && !flush) begin
      acc_seg++;
      if (out_last) lasts_seg++;
    end
  endtask

  task automatic advance();
    @(posedge clock);
    if (!reset_n || flush) begin
      model_zero();
    end else begin
      if (e_wr)  w_cnt++;
      if (e_rd)  r_cnt++;
      if (e_acc) outcnt++;
    end
    #1;
  endtask

  task automatic step(input logic iv, input logic ordy, input logic fl);
    drive(iv, ordy, fl);
    check_model();
    advance();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_zero();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    //            iv    ordy  ir    we    wa    re    ra    ov    ol    bs
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 1'b0, 4'h1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0, 4'h1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 4'h1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 4'h1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0, 4'h1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0, 4'h1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0, 1'b0, 4'h1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 4'h2};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 4'h3};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0, 4'h3};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd3, 1'b1, 1'b0, 4'h3};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd4, 1'b1, 1'b0, 4'h3};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1, 1'b0, 4'h3};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd6, 1'b1, 1'b0, 4'h3};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 3'd7, 1'b1, 1'b0, 4'h3};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1, 4'h0};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'h0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    din       = 0;
    model_zero();
    @(posedge clock);
    #1;

    // Single frame, cycle-exact against the table.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      drive(tbl[k].iv, tbl[k].ordy, 1'b0);
      check_model();
      chk($sformatf("tbl%0d_in_ready", k),   in_ready,   tbl[k].ir);
      chk($sformatf("tbl%0d_wr_en", k),      wr_en,      tbl[k].we);
      chk($sformatf("tbl%0d_wr_addr", k),    wr_addr,    tbl[k].wa);
      chk($sformatf("tbl%0d_rd_en", k),      rd_en,      tbl[k].re);
      chk($sformatf("tbl%0d_rd_addr", k),    rd_addr,    tbl[k].ra);
      chk($sformatf("tbl%0d_out_valid", k),  out_valid,  tbl[k].ov);
      chk($sformatf("tbl%0d_out_last", k),   out_last,   tbl[k].ol);
      chk($sformatf("tbl%0d_bank_state", k), bank_state, tbl[k].bs);
      advance();
    end

    // Three back-to-back frames: no input bubbles, 24 contiguous outputs.
    do_reset();
    run   = 0;
    total = 0;
    ended = 1'b0;
    for (int k = 0; k < 44; k++) begin
      drive((k < 24) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      check_model();
      if (k < 24) chk("c3_in_ready", in_ready, 1);
      if (k < 24 && (k % 8 == 0)) chk($sformatf("c3_wr_bank_f%0d", k / 8), wr_bank, (k / 8) % 2);
      if (out_valid) begin
        total++;
        if (!ended) run++;
      end else if (total > 0) begin
        ended = 1'b1;
      end
      advance();
    end
    chk("c3_ov_run", run, 24);
    chk("c3_ov_total", total, 24);

    // Downstream stalls from the end of frame 1: writer fills bank B and
    // blocks. Bank A has already taken its first read, so it is DRAINING.
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check_model();
    chk("st_rd_first", rd_en, 1);
    advance();
    for (int k = 9; k <= 20; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      check_model();
      chk("st_rd_hold", rd_en, 0);
      if (k >= 16) begin
        chk("st_in_ready", in_ready, 0);
        chk("st_banks", bank_state, 4'hB);
      end
      advance();
    end
    for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 1'b0);
    chk("st_accepted", acc_seg, 16);

    // Flush on sample 3 of frame 2 while frame 1 drains.
    do_reset();
    for (int k = 0; k < 11; k++) step(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    check_model();
    chk("fl_in_ready", in_ready, 0);
    chk("fl_wr_en", wr_en, 0);
    chk("fl_rd_en", rd_en, 0);
    advance();
    drive(1'b1, 1'b1, 1'b0);
    check_model();
    chk("fl_banks", bank_state, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_wr_bank", wr_bank, 0);
    chk("fl_wr_addr", wr_addr, 0);
    chk("fl_wr_en", wr_en, 1);
    advance();
    for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) step(1'b0, 1'b1, 1'b0);
    chk("fl_accepted", acc_seg, 8);

    // Asynchronous reset in the middle of a drain, between clock edges.
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    #2;
    chk("ar_pre_out_valid", out_valid, 1);
    reset_n = 1'b0;
    model_zero();
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_last", out_last, 0);
    chk("ar_banks", bank_state, 0);
    chk("ar_rd_addr", rd_addr, 0);
    chk("ar_wr_addr", wr_addr, 0);
    chk("ar_rd_en", rd_en, 0);
    chk("ar_in_ready", in_ready, 0);
    check_model();
    advance();
    step(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // Random traffic with occasional flushes, then drain.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      iv_r = ($urandom_range(0, 9) < 7);
      or_r = $urandom_range(0, 1) != 0;
      fl_r = ($urandom_range(0, 299) == 0);
      step(iv_r, or_r, fl_r);
    end
    for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 1'b0);
    chk("rnd_accepted", acc_seg, (w_cnt / N) * N);
    chk("rnd_lasts", lasts_seg, w_cnt / N);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
